// File: rtl/dmac_reg_bank.sv
// Channel-0 DMAC register bank: latches the AHB offset, commits slave writes,
// and tracks channel enable/start and terminal-count interrupt state.
module dmac_reg_bank #(
    parameter int ADDR_W = 12
) (
    input  logic              s_HCLK,
    input  logic              s_HRESETn,
    input  logic [31:0]       s_HADDR,
    input  logic [31:0]       s_HWDATA,
    input  logic              load_ahb_addr,
    input  logic              write_out_reg,
    input  logic              ch_done,
    output logic [ADDR_W-1:0] DMAC_HADDR_REG,
    output logic [31:0]       DMAC_Configuration,
    output logic [31:0]       DMAC_C0_SrcAddr,
    output logic [31:0]       DMAC_C0_DestAddr,
    output logic [31:0]       DMAC_C0_Control,
    output logic [31:0]       DMAC_C0_Configuration,
    output logic              DMACINTR_pend,
    output logic              DMACINTR_mask,
    output logic              DMACINTR,
    output logic              ch_active,
    output logic              ch_start
);

    localparam logic [ADDR_W-1:0] OFF_CFG  = ADDR_W'('h030);
    localparam logic [ADDR_W-1:0] OFF_SRC  = ADDR_W'('h100);
    localparam logic [ADDR_W-1:0] OFF_DST  = ADDR_W'('h104);
    localparam logic [ADDR_W-1:0] OFF_CTL  = ADDR_W'('h10C);
    localparam logic [ADDR_W-1:0] OFF_CCFG = ADDR_W'('h110);

    logic [ADDR_W-1:0] haddr;
    logic              e;
    logic              ce;
    logic [31:0]       src;
    logic [31:0]       dst;
    logic [14:0]       ctl;
    logic              pend;
    logic              mask;
    logic              active_q;
    logic              start_r;

    logic wr_cfg, wr_src, wr_dst, wr_ctl, wr_ccfg;

    assign ch_active = e & ce;

    // Source, destination and control are frozen while the channel runs.
    always_comb begin
        wr_cfg  = write_out_reg && (haddr == OFF_CFG);
        wr_src  = write_out_reg && (haddr == OFF_SRC) && !ch_active;
        wr_dst  = write_out_reg && (haddr == OFF_DST) && !ch_active;
        wr_ctl  = write_out_reg && (haddr == OFF_CTL) && !ch_active;
        wr_ccfg = write_out_reg && (haddr == OFF_CCFG);
    end

    always_ff @(posedge s_HCLK or negedge s_HRESETn) begin
        if (!s_HRESETn) begin
            haddr    <= '0;
            e        <= 1'b0;
            ce       <= 1'b0;
            src      <= '0;
            dst      <= '0;
            ctl      <= '0;
            pend     <= 1'b0;
            mask     <= 1'b0;
            active_q <= 1'b0;
            start_r  <= 1'b0;
        end else begin
            if (load_ahb_addr)
                haddr <= s_HADDR[ADDR_W-1:0];
            if (wr_cfg)
                e <= s_HWDATA[0];
            if (wr_src)
                src <= s_HWDATA;
            if (wr_dst)
                dst <= s_HWDATA;
            if (wr_ctl)
                ctl <= s_HWDATA[14:0];
            if (wr_ccfg) begin
                ce   <= s_HWDATA[0];
                mask <= s_HWDATA[1];
                if (s_HWDATA[2])
                    pend <= 1'b0;
            end
            // Terminal count overrides a coincident software write.
            if (ch_done) begin
                ce   <= 1'b0;
                pend <= 1'b1;
            end
            active_q <= ch_active;
            start_r  <= ch_active & ~active_q;
        end
    end

    assign DMAC_HADDR_REG        = haddr;
    assign DMAC_Configuration    = {31'b0, e};
    assign DMAC_C0_SrcAddr       = src;
    assign DMAC_C0_DestAddr      = dst;
    assign DMAC_C0_Control       = {17'b0, ctl};
    assign DMAC_C0_Configuration = {31'b0, ce};
    assign DMACINTR_pend         = pend;
    assign DMACINTR_mask         = mask;
    assign DMACINTR              = pend & mask;
    assign ch_start              = start_r;

endmodule

// File: tb/tb_dmac_reg_bank.sv
// Bench for dmac_reg_bank: directed test-plan sequence followed by random
// traffic, all outputs compared every cycle against a register-map model.
module tb_dmac_reg_bank;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] haddr_in = '0;
    logic [31:0] hwdata = '0;
    logic        load = 1'b0;
    logic        wr = 1'b0;
    logic        done = 1'b0;

    logic [11:0] o_haddr;
    logic [31:0] o_cfg, o_src, o_dst, o_ctl, o_ccfg;
    logic        o_pend, o_mask, o_intr, o_active, o_start;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dmac_reg_bank #(.ADDR_W(12)) dut (
        .s_HCLK(clk), .s_HRESETn(rst_n), .s_HADDR(haddr_in), .s_HWDATA(hwdata),
        .load_ahb_addr(load), .write_out_reg(wr), .ch_done(done),
        .DMAC_HADDR_REG(o_haddr), .DMAC_Configuration(o_cfg),
        .DMAC_C0_SrcAddr(o_src), .DMAC_C0_DestAddr(o_dst),
        .DMAC_C0_Control(o_ctl), .DMAC_C0_Configuration(o_ccfg),
        .DMACINTR_pend(o_pend), .DMACINTR_mask(o_mask), .DMACINTR(o_intr),
        .ch_active(o_active), .ch_start(o_start)
    );

    // Model: register map keyed by offset, each with its writable bit mask.
    logic [31:0] m_reg  [logic [11:0]];
    logic [31:0] m_wmsk [logic [11:0]];
    logic [11:0] m_haddr;
    logic        m_pend, m_start, m_prev_act;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic m_active();
        return m_reg[12'h030][0] & m_reg[12'h110][0];
    endfunction

    task automatic model_reset();
        m_reg[12'h030] = '0; m_wmsk[12'h030] = 32'h0000_0001;
        m_reg[12'h100] = '0; m_wmsk[12'h100] = 32'hFFFF_FFFF;
        m_reg[12'h104] = '0; m_wmsk[12'h104] = 32'hFFFF_FFFF;
        m_reg[12'h10C] = '0; m_wmsk[12'h10C] = 32'h0000_7FFF;
        m_reg[12'h110] = '0; m_wmsk[12'h110] = 32'h0000_0003;
        m_haddr = '0; m_pend = 0; m_start = 0; m_prev_act = 0;
    endtask

    task automatic compare_all(input string where);
        check({where, ":haddr"},  {20'b0, o_haddr}, {20'b0, m_haddr});
        check({where, ":cfg"},    o_cfg,  m_reg[12'h030]);
        check({where, ":src"},    o_src,  m_reg[12'h100]);
        check({where, ":dst"},    o_dst,  m_reg[12'h104]);
        check({where, ":ctl"},    o_ctl,  m_reg[12'h10C]);
        check({where, ":ccfg"},   o_ccfg, {31'b0, m_reg[12'h110][0]});
        check({where, ":pend"},   {31'b0, o_pend},   {31'b0, m_pend});
        check({where, ":mask"},   {31'b0, o_mask},   {31'b0, m_reg[12'h110][1]});
        check({where, ":intr"},   {31'b0, o_intr},   {31'b0, m_pend & m_reg[12'h110][1]});
        check({where, ":active"}, {31'b0, o_active}, {31'b0, m_active()});
        check({where, ":start"},  {31'b0, o_start},  {31'b0, m_start});
    endtask

    // One clock: drive at negedge, apply spec rules to pre-edge model state, compare after edge.
    task automatic cycle(input logic l, input logic [31:0] a, input logic w,
                         input logic [31:0] d, input logic dn, input string where);
        logic        act;
        logic [11:0] tgt;
        @(negedge clk);
        load = l; haddr_in = a; wr = w; hwdata = d; done = dn;
        act = m_active();
        tgt = m_haddr;
        @(posedge clk);
        #1;
        if (w && m_reg.exists(tgt)) begin
            if (!(act && (tgt == 12'h100 || tgt == 12'h104 || tgt == 12'h10C)))
                m_reg[tgt] = d & m_wmsk[tgt];
            if (tgt == 12'h110 && d[2])
                m_pend = 0;
        end
        if (dn) begin
            m_reg[12'h110][0] = 1'b0;
            m_pend = 1;
        end
        if (l) m_haddr = a[11:0];
        m_start = act & ~m_prev_act;
        m_prev_act = act;
        compare_all(where);
    endtask

    task automatic idle(input string where);
        cycle(0, 32'h0, 0, 32'h0, 0, where);
    endtask

    initial begin
        logic [11:0] pool [7];
        logic [31:0] a, d;
        pool[0] = 12'h030; pool[1] = 12'h100; pool[2] = 12'h104; pool[3] = 12'h10C;
        pool[4] = 12'h110; pool[5] = 12'h108; pool[6] = 12'h000;

        model_reset();
        #12;
        compare_all("reset");
        check("reset_haddr", {20'b0, o_haddr}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Address then data write
        cycle(1, 32'h0000_0100, 0, 32'h0, 0, "ld100");
        cycle(0, 32'h0, 1, 32'hDEAD_BEEF, 0, "wr100");
        check("src_write", o_src, 32'hDEAD_BEEF);
        check("haddr_100", {20'b0, o_haddr}, 32'h100);

        // Back-to-back writes
        cycle(1, 32'h0000_0104, 0, 32'h0, 0, "ld104");
        cycle(1, 32'h0000_010C, 1, 32'h1234_5678, 0, "wr104_ld10c");
        cycle(0, 32'h0, 1, 32'hFFFF_FFFF, 0, "wr10c");
        check("dst_b2b", o_dst, 32'h1234_5678);
        check("ctl_b2b", o_ctl, 32'h0000_7FFF);

        // Start and lock
        cycle(1, 32'h0000_0030, 0, 32'h0, 0, "ld030");
        cycle(1, 32'h0000_0110, 1, 32'h1, 0, "wr030");
        cycle(0, 32'h0, 1, 32'h3, 0, "wr110");
        check("active_on", {31'b0, o_active}, 32'h1);
        check("start_not_yet", {31'b0, o_start}, 32'h0);
        idle("start1");
        check("start_pulse", {31'b0, o_start}, 32'h1);
        cycle(1, 32'h0000_0100, 0, 32'h0, 0, "ld100b");
        check("start_single", {31'b0, o_start}, 32'h0);
        cycle(0, 32'h0, 1, 32'h0, 0, "wr100_locked");
        check("src_locked", o_src, 32'hDEAD_BEEF);

        // Completion then clear
        cycle(1, 32'h0000_0110, 0, 32'h0, 1, "done");
        check("done_ce", o_ccfg, 32'h0);
        check("done_intr", {31'b0, o_intr}, 32'h1);
        cycle(0, 32'h0, 1, 32'h6, 0, "clr_pend");
        check("clr_pend", {31'b0, o_pend}, 32'h0);
        check("clr_intr", {31'b0, o_intr}, 32'h0);
        check("clr_mask", {31'b0, o_mask}, 32'h1);

        // Collision of done with a CCFG write
        cycle(0, 32'h0, 1, 32'h3, 0, "rearm");
        idle("rearm_start");
        check("rearm_start", {31'b0, o_start}, 32'h1);
        cycle(0, 32'h0, 1, 32'h5, 1, "collide");
        check("coll_ce", o_ccfg, 32'h0);
        check("coll_pend", {31'b0, o_pend}, 32'h1);
        check("coll_mask", {31'b0, o_mask}, 32'h0);

        // Bad offset
        cycle(1, 32'h0000_0108, 0, 32'h0, 0, "ld108");
        cycle(0, 32'h0, 1, 32'hFFFF_FFFF, 0, "wr108");
        check("bad_src", o_src, 32'hDEAD_BEEF);
        check("bad_dst", o_dst, 32'h1234_5678);

        // Async reset while active
        cycle(1, 32'h0000_0110, 0, 32'h0, 0, "ld110");
        cycle(0, 32'h0, 1, 32'h3, 0, "act_again");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all("async_rst");
        check("rst_active", {31'b0, o_active}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle("post_rst1");
        idle("post_rst2");
        check("no_start_rel", {31'b0, o_start}, 32'h0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            a = {20'b0, pool[$urandom_range(0, 6)]};
            if ($urandom_range(0, 9) == 0) a = $urandom;
            d = $urandom;
            if ($urandom_range(0, 1) == 1) d[0] = 1'b1;
            cycle(1'($urandom_range(0, 1)), a, 1'($urandom_range(0, 1)), d,
                  ($urandom_range(0, 9) == 0), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
